seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle unsigned restoring divider that sits directly downstream of the frequency-meter core. It accepts the measurement numerator (cnt_fx × reference frequency) and denominator (reference-clock count) and returns the quotient, which is the measured frequency, and the remainder. It resolves one quotient bit per clock and uses an en/ready/vld_out handshake on the system clock.

## Interface
- WIDTH, 57, operand and result width in bits (dividend, divisor, quotient, remainder).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

- sys_clk  input  1  system clock (50 MHz); all logic is on this clock.
- sys_rst_n  input  1  asynchronous, active-low reset.
- en  input  1  start request; level signal, may stay high until vld_out is seen.
- dividend  input  WIDTH  unsigned numerator; sampled on the accept edge only.
- divisor  input  WIDTH  unsigned denominator; sampled on the accept edge only.
- ready  output  1  high only in IDLE; operands can be accepted.
- quotient  output  WIDTH  registered result; holds until the next completion.
- remainder  output  WIDTH  registered result; holds until the next completion.
- vld_out  output  1  one-cycle pulse; quotient and remainder are valid and new.
- div_zero  output  1  registered with vld_out; the completed operation had divisor == 0; holds until the next completion.

## Operation
- States:
  - IDLE: ready=1.
  - CALC: ready=0, iterates.
  - DONE: ready=0, vld_out=1.
- IDLE→CALC on the edge where en && ready. That edge loads dv_r ← divisor, q_sh ← dividend, rem_r ← 0 (WIDTH+1 bits), cnt ← 0.
- CALC iteration, every cycle:
  - t = {rem_r[WIDTH-1:0], q_sh[WIDTH-1]}.
  - If t ≥ {1'b0, dv_r}: rem_r ← t − dv_r and shift 1 into q_sh LSB.
  - Otherwise: rem_r ← t and shift 0 in.
  - cnt ← cnt + 1.
- CALC→DONE on the edge that performs iteration WIDTH (cnt == WIDTH−1). That same edge loads:
  - quotient ← final q_sh
  - remainder ← final rem_r[WIDTH-1:0]
  - div_zero ← (dv_r == 0)
  - vld_out ← 1
- DONE→IDLE unconditionally after one cycle; vld_out ← 0.
- Divisor 0 needs no special path. The algorithm naturally yields quotient = all ones and remainder = dividend; div_zero flags the case.
- en is ignored outside IDLE. Deasserting en mid-CALC does not abort the operation.
- ready is low in DONE. An upstream en that is cleared on the vld_out edge therefore cannot retrigger. If en is still high when the block returns to IDLE, a new operation starts on that edge.
- Arithmetic is fully unsigned. The comparison and subtraction are WIDTH+1 bits wide, and remainder < divisor always holds for divisor ≠ 0.

## Timing
- Reset values: ready=1 (state IDLE), vld_out=0, quotient=0, remainder=0, div_zero=0. Internal registers are cleared to 0.
- Asserting sys_rst_n low at any time, including mid-CALC or in DONE, returns the block to IDLE immediately. Outputs take reset values and the in-flight result is discarded, with no vld_out.
- Latency: with the accept edge as edge 0, vld_out is high in the cycle following edge WIDTH (edge 57 by default). Results update on that same edge.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is edge WIDTH+2.
- Operand inputs may change freely after the accept edge.
- vld_out is exactly one cycle wide per accepted operation.

## Test plan
- Nominal measurement:
  - Stimulus: dividend=100_000_000_000, divisor=100_000_000, en held high until vld_out.
  - Required: quotient=1000, remainder=0, div_zero=0, vld_out in the cycle after edge 57, exactly one pulse; ready=0 from edge 1 through edge 58.
- Remainder and small-quotient cases:
  - 1_234_567 / 1000 → quotient 1234, remainder 567.
  - 3 / 7 → quotient 0, remainder 3.
  - (2^57−1) / 1 → quotient 2^57−1, remainder 0.
- Divide by zero:
  - Stimulus: dividend=5, divisor=0.
  - Required: quotient=2^57−1, remainder=5, div_zero=1 with vld_out. A following 10/2 → quotient 5 and clears div_zero.
- Handshake:
  - Stimulus 1: hold en high continuously across vld_out.
  - Required 1: a second accept at edge 59, with the second vld_out after edge 116.
  - Stimulus 2: drop en during CALC, then change the operands.
  - Required 2: the original result is unaffected.
- Reset mid-operation:
  - Stimulus: assert sys_rst_n low 20 cycles after an accept.
  - Required: ready=1 and all outputs 0 asynchronously, with no vld_out. A subsequent 1000/8 → quotient 125, remainder 0.

Source files
------------

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between the frequency-meter core and seq_divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 57
);
    logic             en;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             vld_out;
    logic             div_zero;

    modport master (
        output en, dividend, divisor,
        input  ready, quotient, remainder, vld_out, div_zero
    );

    modport slave (
        input  en, dividend, divisor,
        output ready, quotient, remainder, vld_out, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, en/ready/vld_out handshake.
module seq_divider #(
    parameter int unsigned WIDTH = 57,
    parameter int unsigned CNT_W = 6
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    seq_divider_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dv_q;
    logic [WIDTH-1:0] q_sh_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             ready_q;
    logic             vld_out_q;
    logic             div_zero_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   dv_ext;
    logic             ge;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] q_sh_d;

    // One restoring step; the remainder always fits in WIDTH bits because it stays below the divisor.
    always_comb begin
        trial  = {rem_q, q_sh_q[WIDTH-1]};
        dv_ext = {1'b0, dv_q};
        ge     = (trial >= dv_ext);
        rem_d  = ge ? WIDTH'(trial - dv_ext) : trial[WIDTH-1:0];
        q_sh_d = {q_sh_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dv_q        <= '0;
            q_sh_q      <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b1;
            vld_out_q   <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.en) begin
                        state_q <= S_CALC;
                        dv_q    <= bus.divisor;
                        q_sh_q  <= bus.dividend;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    rem_q  <= rem_d;
                    q_sh_q <= q_sh_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= S_DONE;
                        quotient_q  <= q_sh_d;
                        remainder_q <= rem_d;
                        div_zero_q  <= (dv_q == '0);
                        vld_out_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    vld_out_q <= 1'b0;
                    ready_q   <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    vld_out_q <= 1'b0;
                    ready_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.vld_out   = vld_out_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against plain unsigned division.
module tb_seq_divider;
    localparam int unsigned W = 57;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: divide-by-zero yields all ones and returns the dividend as remainder.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    // Assumes the block is idle at the current sample point; returns just after the edge following vld_out.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit drop_mid, input bit keep_en);
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        int           cycles;
        bit           rdy_bad;
        exp_q = ref_q(a, b);
        exp_r = ref_r(a, b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.en       = 1'b1;
        check({tag, ".ready_pre"}, 64'(bus.ready), 64'd1);
        tick();
        check({tag, ".ready_acc"}, 64'(bus.ready), 64'd0);
        cycles  = 0;
        rdy_bad = 1'b0;
        while (!bus.vld_out && cycles < 200) begin
            if (drop_mid && cycles == 5) begin
                bus.en       = 1'b0;
                bus.dividend = W'({$urandom, $urandom});
                bus.divisor  = W'({$urandom, $urandom});
            end
            tick();
            cycles++;
            if (bus.ready) rdy_bad = 1'b1;
        end
        check({tag, ".latency"}, 64'(cycles), 64'(W));
        check({tag, ".ready_busy"}, 64'(rdy_bad), 64'd0);
        if (!keep_en) bus.en = 1'b0;
        check({tag, ".quotient"}, 64'(bus.quotient), 64'(exp_q));
        check({tag, ".remainder"}, 64'(bus.remainder), 64'(exp_r));
        check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(b == '0));
        tick();
        check({tag, ".vld_one"}, 64'(bus.vld_out), 64'd0);
        check({tag, ".ready_ret"}, 64'(bus.ready), 64'd1);
        check({tag, ".q_hold"}, 64'(bus.quotient), 64'(exp_q));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           seen_vld;
        n_cmp        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        tick();
        tick();
        check("rst.ready", 64'(bus.ready), 64'd1);
        check("rst.vld", 64'(bus.vld_out), 64'd0);
        check("rst.q", 64'(bus.quotient), 64'd0);
        check("rst.r", 64'(bus.remainder), 64'd0);
        check("rst.dz", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op("nominal", W'(64'd100_000_000_000), W'(64'd100_000_000), 1'b0, 1'b0);
        tick();
        do_op("rem", W'(64'd1_234_567), W'(64'd1000), 1'b0, 1'b0);
        do_op("small", W'(64'd3), W'(64'd7), 1'b0, 1'b0);
        do_op("max_by1", {W{1'b1}}, W'(64'd1), 1'b0, 1'b0);
        do_op("dz", W'(64'd5), '0, 1'b0, 1'b0);
        do_op("after_dz", W'(64'd10), W'(64'd2), 1'b0, 1'b0);

        // Back-to-back: en held through vld_out starts the next op on the return to IDLE.
        do_op("b2b_a", W'(64'd987_654_321), W'(64'd12_345), 1'b0, 1'b1);
        do_op("b2b_b", W'(64'd555), W'(64'd5), 1'b0, 1'b0);

        do_op("drop_en", W'(64'd77_777_777), W'(64'd333), 1'b1, 1'b0);

        // Reset 20 cycles after accept: outputs clear asynchronously and no result appears.
        bus.dividend = W'(64'd999_999);
        bus.divisor  = W'(64'd7);
        bus.en       = 1'b1;
        tick();
        bus.en = 1'b0;
        repeat (20) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst.ready", 64'(bus.ready), 64'd1);
        check("mid_rst.vld", 64'(bus.vld_out), 64'd0);
        check("mid_rst.q", 64'(bus.quotient), 64'd0);
        check("mid_rst.r", 64'(bus.remainder), 64'd0);
        check("mid_rst.dz", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        seen_vld = 1'b0;
        repeat (60) begin
            tick();
            if (bus.vld_out) seen_vld = 1'b1;
        end
        check("mid_rst.no_vld", 64'(seen_vld), 64'd0);
        do_op("post_rst", W'(64'd1000), W'(64'd8), 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = W'({$urandom, $urandom}) >> $urandom_range(20, 0);
            rb = W'({$urandom, $urandom}) >> $urandom_range(56, 0);
            if (i % 7 == 3) rb = '0;
            do_op($sformatf("rand%0d", i), ra, rb, (i % 4 == 1), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
